// File: rtl/game_pkg.sv
// Shared definitions for the two-player number game: datapath widths,
// debounce default and the FSM state encoding used by the game controller.
package game_pkg;

  // Default datapath widths
  localparam int unsigned NUM_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 2;

  // 10 ms of button stability at a 100 MHz clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

  // Game FSM state encoding (owned by the controller, kept here so both agree)
  localparam int unsigned STATE_W = 4;
  localparam logic [STATE_W-1:0] ST_IDLE          = 4'd0;
  localparam logic [STATE_W-1:0] ST_P1_ENTRY      = 4'd1;
  localparam logic [STATE_W-1:0] ST_P2_ENTRY      = 4'd2;
  localparam logic [STATE_W-1:0] ST_COMPARE       = 4'd3;
  localparam logic [STATE_W-1:0] ST_P1_WINS_ROUND = 4'd4;
  localparam logic [STATE_W-1:0] ST_P2_WINS_ROUND = 4'd5;
  localparam logic [STATE_W-1:0] ST_P1_WINS_GAME  = 4'd6;
  localparam logic [STATE_W-1:0] ST_P2_WINS_GAME  = 4'd7;
  localparam logic [STATE_W-1:0] ST_CLEAR         = 4'd8;

  // Width of a counter that must reach cycles-1 (at least one bit)
  function automatic int unsigned db_cnt_w(input int unsigned cycles);
    int unsigned w;
    w = 1;
    while ((cycles > 1) && ((64'd1 << w) < 64'(cycles))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : game_pkg

// File: rtl/btn_conditioner.sv
// One push-button: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Debounce stage present only when GAME_INPUT_DEBOUNCE_EN is defined;
// otherwise the stable level is the synchroniser output.
module btn_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic level_d;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef GAME_INPUT_DEBOUNCE_EN
  localparam int unsigned DB_W = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            level_q;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt  <= '0;
      level_q <= 1'b0;
    end else if (sync_q2 == level_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level_q <= sync_q2;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign level = level_q;
`else
  // Debounce removed: the synchronised value is taken as stable
  assign level = sync_q2;

  // DEBOUNCE_CYCLES has no effect in this build; zero is still nonsensical
  if (DEBOUNCE_CYCLES == 0) begin : g_zero_debounce_cfg
  end
`endif

  // Single-cycle pulse on the rising edge of the stable level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule : btn_conditioner

// File: rtl/game_input_score.sv
// Input/score datapath for the number-game FSM: conditions the three
// buttons, latches each player's switch entry and keeps round-win counts.
// Optional macro GAME_INPUT_DEBOUNCE_EN enables the debounce counters.
module game_input_score
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned NUM_W           = NUM_W_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_p1_raw,
  input  logic             btn_mid_raw,
  input  logic             btn_p2_raw,
  input  logic [NUM_W-1:0] sw,
  input  logic             start,
  input  logic             p2input,
  input  logic             p1winsround,
  input  logic             p2winsround,
  input  logic             idle,
  input  logic             clearstate,
  output logic             p1,
  output logic             mid,
  output logic             p2,
  output logic [NUM_W-1:0] p1number,
  output logic [NUM_W-1:0] p2number,
  output logic [CNT_W-1:0] p1count,
  output logic [CNT_W-1:0] p2count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clear;
  logic one_winner;

  assign clear      = idle | clearstate;
  assign one_winner = p1winsround ^ p2winsround;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_p1_raw),
    .pulse   (p1)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mid (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_mid_raw),
    .pulse   (mid)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_p2_raw),
    .pulse   (p2)
  );

  // Capture each player's entry on their press during their own entry state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1number <= '0;
      p2number <= '0;
    end else if (clear) begin
      p1number <= '0;
      p2number <= '0;
    end else begin
      if (p1 && start) begin
        p1number <= sw;
      end
      if (p2 && p2input) begin
        p2number <= sw;
      end
    end
  end

  // Saturating round-win counters; a simultaneous win flag pair is ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1count <= '0;
      p2count <= '0;
    end else if (clear) begin
      p1count <= '0;
      p2count <= '0;
    end else if (one_winner) begin
      if (p1winsround && (p1count != CNT_MAX)) begin
        p1count <= p1count + CNT_W'(1);
      end
      if (p2winsround && (p2count != CNT_MAX)) begin
        p2count <= p2count + CNT_W'(1);
      end
    end
  end

endmodule : game_input_score

// File: tb/tb_game_input_score.sv
// Directed, self-checking bench for game_input_score (DEBOUNCE_CYCLES=4).
module tb_game_input_score;

  localparam int unsigned DB = 4;
`ifdef GAME_INPUT_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       reset_n;
  logic [2:0] raw;
  logic [7:0] sw;
  logic       start, p2input, p1winsround, p2winsround, idle, clearstate;
  logic       p1, mid, p2;
  logic [7:0] p1number, p2number;
  logic [1:0] p1count, p2count;
  logic [2:0] pulses;

  int errors = 0;
  int checks = 0;

  assign pulses = {p2, mid, p1};

  game_input_score #(.DEBOUNCE_CYCLES(DB), .NUM_W(8), .CNT_W(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_p1_raw  (raw[0]),
    .btn_mid_raw (raw[1]),
    .btn_p2_raw  (raw[2]),
    .sw          (sw),
    .start       (start),
    .p2input     (p2input),
    .p1winsround (p1winsround),
    .p2winsround (p2winsround),
    .idle        (idle),
    .clearstate  (clearstate),
    .p1          (p1),
    .mid         (mid),
    .p2          (p2),
    .p1number    (p1number),
    .p2number    (p2number),
    .p1count     (p1count),
    .p2count     (p2count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       p1w;
    logic       p2w;
    logic       idl;
    logic       clr;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [7:0] n1;
    logic [7:0] n2;
  } vec_t;

  function automatic vec_t mk(input logic a, b, c, d, input logic [1:0] e1, e2,
                              input logic [7:0] m1, m2);
    vec_t v;
    v.p1w = a; v.p2w = b; v.idl = c; v.clr = d;
    v.c1 = e1; v.c2 = e2; v.n1 = m1; v.n2 = m2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Press button b cleanly and hold; expect a single pulse LAT cycles later
  task automatic press(input int b, input string nm);
    logic [2:0] exp;
    raw[b] = 1'b1;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      exp = (i == LAT) ? (3'b001 << b) : 3'b000;
      chk($sformatf("%s pulse t%0d", nm, i), 32'(pulses), 32'(exp));
    end
  endtask

  // Release button b; no pulse may follow
  task automatic release_btn(input int b, input string nm);
    raw[b] = 1'b0;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      chk($sformatf("%s release t%0d", nm, i), 32'(pulses), 32'd0);
    end
  endtask

  vec_t vecs[16];

  initial begin
    reset_n = 1'b0; raw = 3'b000; sw = 8'h00;
    start = 1'b0; p2input = 1'b0; p1winsround = 1'b0; p2winsround = 1'b0;
    idle = 1'b0; clearstate = 1'b0;

    vecs[0]  = mk(1, 0, 0, 0, 2'd1, 2'd0, 8'h5A, 8'h33);
    vecs[1]  = mk(0, 0, 0, 0, 2'd1, 2'd0, 8'h5A, 8'h33);
    vecs[2]  = mk(1, 0, 0, 0, 2'd2, 2'd0, 8'h5A, 8'h33);
    vecs[3]  = mk(0, 0, 0, 0, 2'd2, 2'd0, 8'h5A, 8'h33);
    vecs[4]  = mk(1, 0, 0, 0, 2'd3, 2'd0, 8'h5A, 8'h33);
    vecs[5]  = mk(1, 0, 0, 0, 2'd3, 2'd0, 8'h5A, 8'h33);
    vecs[6]  = mk(0, 1, 0, 0, 2'd3, 2'd1, 8'h5A, 8'h33);
    vecs[7]  = mk(1, 1, 0, 0, 2'd3, 2'd1, 8'h5A, 8'h33);
    vecs[8]  = mk(0, 1, 0, 1, 2'd0, 2'd0, 8'h00, 8'h00);
    vecs[9]  = mk(0, 1, 0, 0, 2'd0, 2'd1, 8'h00, 8'h00);
    vecs[10] = mk(1, 0, 1, 0, 2'd0, 2'd0, 8'h00, 8'h00);
    vecs[11] = mk(0, 1, 0, 0, 2'd0, 2'd1, 8'h00, 8'h00);
    vecs[12] = mk(0, 1, 0, 0, 2'd0, 2'd2, 8'h00, 8'h00);
    vecs[13] = mk(0, 1, 0, 0, 2'd0, 2'd3, 8'h00, 8'h00);
    vecs[14] = mk(0, 1, 0, 0, 2'd0, 2'd3, 8'h00, 8'h00);
    vecs[15] = mk(0, 0, 0, 1, 2'd0, 2'd0, 8'h00, 8'h00);

    // Reset state
    tick(); tick();
    chk("reset pulses", 32'(pulses), 32'd0);
    chk("reset p1number", 32'(p1number), 32'd0);
    chk("reset p2number", 32'(p2number), 32'd0);
    chk("reset p1count", 32'(p1count), 32'd0);
    chk("reset p2count", 32'(p2count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Player-1 entry latch
    start = 1'b1; sw = 8'h5A;
    press(0, "p1 start");
    chk("p1number latched", 32'(p1number), 32'h5A);
    chk("p2number untouched", 32'(p2number), 32'h00);
    release_btn(0, "p1 start");
    start = 1'b0;

    // Player-2 entry latch
    p2input = 1'b1; sw = 8'h33;
    press(2, "p2 entry");
    chk("p2number latched", 32'(p2number), 32'h33);
    chk("p1number kept", 32'(p1number), 32'h5A);
    release_btn(2, "p2 entry");
    p2input = 1'b0;

    // Press outside the entry state is ignored by the latch
    sw = 8'hFF;
    press(0, "p1 no start");
    chk("p1number ignored press", 32'(p1number), 32'h5A);
    release_btn(0, "p1 no start");

    // Centre button
    press(1, "mid");
    chk("numbers after mid", 32'({p1number, p2number}), 32'h5A33);
    release_btn(1, "mid");

    // Score counters, saturation, illegal pair, clear priority
    for (int i = 0; i < 16; i++) begin
      p1winsround = vecs[i].p1w; p2winsround = vecs[i].p2w;
      idle = vecs[i].idl; clearstate = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d p1count", i), 32'(p1count), 32'(vecs[i].c1));
      chk($sformatf("vec%0d p2count", i), 32'(p2count), 32'(vecs[i].c2));
      chk($sformatf("vec%0d p1number", i), 32'(p1number), 32'(vecs[i].n1));
      chk($sformatf("vec%0d p2number", i), 32'(p2number), 32'(vecs[i].n2));
    end
    p1winsround = 1'b0; p2winsround = 1'b0; idle = 1'b0; clearstate = 1'b0;
    tick();

`ifdef GAME_INPUT_DEBOUNCE_EN
    // Bouncing press: 1,0,1,0 then held; one pulse LAT cycles after final rise
    begin
      int npulse;
      int at;
      npulse = 0; at = -1;
      for (int k = 0; k < 14; k++) begin
        raw[0] = (k < 4) ? ~k[0] : 1'b1;
        tick();
        if (p1) begin
          npulse++;
          at = k;
        end
      end
      chk("bounce pulse count", 32'(npulse), 32'd1);
      chk("bounce pulse cycle", 32'(at), 32'(4 + LAT - 1));
      release_btn(0, "bounce");
    end
`endif

    // Reset mid-conditioning with the button held
    raw[0] = 1'b1; p1winsround = 1'b1;
    tick();
    p1winsround = 1'b0;
    tick();
    chk("pre-reset p1count", 32'(p1count), 32'd1);
    chk("pre-reset pulses", 32'(pulses), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async reset p1count", 32'(p1count), 32'd0);
    chk("async reset pulses", 32'(pulses), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      chk($sformatf("post-reset p1 t%0d", i), 32'(p1), 32'(i == LAT));
    end
    release_btn(0, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_game_input_score
